ahb_uart: RTL and testbench

// AHB-Lite slave UART: 8N1 serial transmitter and receiver, each behind a 16-byte FIFO.

---
 rtl/ahb_uart.sv | 271 +++++++++++++++++++++++++++
 tb/tb_ahb_uart.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/ahb_uart.sv
// ahb_uart: AHB-Lite slave UART with an 8N1 transmitter and receiver.
// Each direction is buffered by a 2**FIFO_AW byte FIFO. The slave has no wait states.
//
// Register map (word addresses, decoded from HADDR[3:2]):
//   0x0 RXDATA  read pops the RX FIFO head (0 when empty); writes are ignored
//   0x4 TXDATA  write pushes a byte into the TX FIFO; read returns the last byte written
//   0x8 STATUS  {rx_not_empty, rx_full, tx_empty, tx_full}, read-only
//   0xC CONTRL  interrupt mask for the STATUS bits, [3:0] read/write
//
// Ports:
//   HCLK, HRESETn         clock and synchronous active-low reset
//   HSEL, HREADY, HADDR,  AHB-Lite address phase inputs
//   HTRANS, HWRITE
//   HWDATA                write data, sampled during the data phase
//   HRDATA, HREADYOUT     read data (combinational on the stored address), always-ready
//   serialRx, serialTx    serial lines, both idle high
//   uart_IRQ              registered level interrupt = |(STATUS & CONTRL)
//
// Bus handshake: a transfer is accepted in its address phase when
// HSEL & HREADY & HTRANS[1]. Its data phase is the following cycle, and
// writes and RX pops take effect on the clock edge that ends that data phase.
module ahb_uart #(
    parameter int CLK_HZ  = 50_000_000,
    parameter int BAUD    = 19_200,
    parameter int FIFO_AW = 4
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic        HREADY,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [31:0] HWDATA,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    input  logic        serialRx,
    output logic        serialTx,
    output logic        uart_IRQ
);
    localparam int DEPTH = 2 ** FIFO_AW;
    localparam int BIT   = CLK_HZ / BAUD;
    localparam int HALF  = BIT / 2;
    localparam int CW    = $clog2(BIT) + 1;
    localparam logic [CW-1:0]      BIT_LAST  = CW'(BIT - 1);
    localparam logic [CW-1:0]      HALF_LAST = CW'(HALF - 1);
    localparam logic [FIFO_AW:0]   FULL_CNT  = (FIFO_AW + 1)'(DEPTH);

    // ---------------- bus front end ----------------
    logic       valid_q, write_q;
    logic [1:0] addr_q;
    logic       accept, wr_en, rd_en;
    logic [3:0] control;
    logic [7:0] last_tx;
    logic       irq_q;

    assign accept    = HSEL & HREADY & HTRANS[1];
    assign wr_en     = valid_q & write_q;
    assign rd_en     = valid_q & ~write_q;
    assign HREADYOUT = 1'b1;
    assign uart_IRQ  = irq_q;

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            valid_q <= 1'b0;
            write_q <= 1'b0;
            addr_q  <= 2'd0;
        end else begin
            valid_q <= accept;
            if (accept) begin
                addr_q  <= HADDR[3:2];
                write_q <= HWRITE;
            end
        end
    end

    // ---------------- TX FIFO ----------------
    logic [7:0]         tx_mem [DEPTH];
    logic [FIFO_AW-1:0] tx_wp, tx_rp;
    logic [FIFO_AW:0]   tx_fcnt;
    logic               tx_full, tx_empty, tx_push, tx_pop;

    assign tx_full  = (tx_fcnt == FULL_CNT);
    assign tx_empty = (tx_fcnt == '0);
    assign tx_push  = wr_en && (addr_q == 2'd1) && !tx_full;

    always_ff @(posedge HCLK) begin
        if (tx_push) tx_mem[tx_wp] <= HWDATA[7:0];
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            tx_wp   <= '0;
            tx_rp   <= '0;
            tx_fcnt <= '0;
        end else begin
            if (tx_push) tx_wp <= tx_wp + 1'b1;
            if (tx_pop)  tx_rp <= tx_rp + 1'b1;
            case ({tx_push, tx_pop})
                2'b10:   tx_fcnt <= tx_fcnt + 1'b1;
                2'b01:   tx_fcnt <= tx_fcnt - 1'b1;
                default: tx_fcnt <= tx_fcnt;
            endcase
        end
    end

    // ---------------- transmitter ----------------
    // The frame register shifts right and its bit 0 drives the line, so the
    // output is registered and idles at 1 once the stop bit has shifted out.
    logic          tx_busy;
    logic [9:0]    tx_frame;
    logic [3:0]    tx_bit;
    logic [CW-1:0] tx_baud;
    logic          tx_bit_end, tx_load;

    assign tx_bit_end = (tx_baud == BIT_LAST);
    // Reload on the last cycle of the stop bit so consecutive frames abut.
    assign tx_load    = !tx_empty && (!tx_busy || (tx_bit_end && tx_bit == 4'd9));
    assign tx_pop     = tx_load;
    assign serialTx   = tx_frame[0];

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            tx_busy  <= 1'b0;
            tx_frame <= '1;
            tx_bit   <= 4'd0;
            tx_baud  <= '0;
        end else if (tx_load) begin
            tx_busy  <= 1'b1;
            tx_frame <= {1'b1, tx_mem[tx_rp], 1'b0};
            tx_bit   <= 4'd0;
            tx_baud  <= '0;
        end else if (tx_busy) begin
            if (tx_bit_end) begin
                tx_baud  <= '0;
                tx_frame <= {1'b1, tx_frame[9:1]};
                if (tx_bit == 4'd9) tx_busy <= 1'b0;
                else                tx_bit  <= tx_bit + 4'd1;
            end else begin
                tx_baud <= tx_baud + 1'b1;
            end
        end
    end

    // ---------------- receiver ----------------
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    rx_state_t     rx_state;
    logic          rx_s1, rx_s2, rx_prev;
    logic [CW-1:0] rx_baud;
    logic [2:0]    rx_bit;
    logic [7:0]    rx_shift, rx_byte;
    logic          rx_done;

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_prev  <= 1'b1;
            rx_state <= RX_IDLE;
            rx_baud  <= '0;
            rx_bit   <= 3'd0;
            rx_shift <= 8'd0;
            rx_byte  <= 8'd0;
            rx_done  <= 1'b0;
        end else begin
            rx_s1   <= serialRx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
            rx_done <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    rx_baud <= '0;
                    if (rx_prev && !rx_s2) rx_state <= RX_START;
                end
                RX_START: begin
                    if (rx_baud == HALF_LAST) begin
                        rx_baud  <= '0;
                        rx_bit   <= 3'd0;
                        // A line that is high again at mid start bit was a glitch.
                        rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_baud <= rx_baud + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (rx_baud == BIT_LAST) begin
                        rx_baud  <= '0;
                        rx_shift <= {rx_s2, rx_shift[7:1]};
                        if (rx_bit == 3'd7) rx_state <= RX_STOP;
                        else                rx_bit   <= rx_bit + 3'd1;
                    end else begin
                        rx_baud <= rx_baud + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (rx_baud == BIT_LAST) begin
                        rx_baud  <= '0;
                        rx_state <= RX_IDLE;
                        if (rx_s2) begin
                            rx_done <= 1'b1;
                            rx_byte <= rx_shift;
                        end
                    end else begin
                        rx_baud <= rx_baud + 1'b1;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    // ---------------- RX FIFO ----------------
    logic [7:0]         rx_mem [DEPTH];
    logic [FIFO_AW-1:0] rx_wp, rx_rp;
    logic [FIFO_AW:0]   rx_fcnt;
    logic               rx_full, rx_empty, rx_push, rx_pop;

    assign rx_full  = (rx_fcnt == FULL_CNT);
    assign rx_empty = (rx_fcnt == '0);
    assign rx_push  = rx_done && !rx_full;
    assign rx_pop   = rd_en && (addr_q == 2'd0) && !rx_empty;

    always_ff @(posedge HCLK) begin
        if (rx_push) rx_mem[rx_wp] <= rx_byte;
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            rx_wp   <= '0;
            rx_rp   <= '0;
            rx_fcnt <= '0;
        end else begin
            if (rx_push) rx_wp <= rx_wp + 1'b1;
            if (rx_pop)  rx_rp <= rx_rp + 1'b1;
            case ({rx_push, rx_pop})
                2'b10:   rx_fcnt <= rx_fcnt + 1'b1;
                2'b01:   rx_fcnt <= rx_fcnt - 1'b1;
                default: rx_fcnt <= rx_fcnt;
            endcase
        end
    end

    // ---------------- registers, read mux, interrupt ----------------
    logic [3:0] status;
    assign status = {!rx_empty, rx_full, tx_empty, tx_full};

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            control <= 4'd0;
            last_tx <= 8'd0;
            irq_q   <= 1'b0;
        end else begin
            if (wr_en && addr_q == 2'd3) control <= HWDATA[3:0];
            if (wr_en && addr_q == 2'd1) last_tx <= HWDATA[7:0];
            irq_q <= |(status & control);
        end
    end

    always_comb begin
        HRDATA = 32'd0;
        case (addr_q)
            2'd0:    HRDATA[7:0] = rx_empty ? 8'd0 : rx_mem[rx_rp];
            2'd1:    HRDATA[7:0] = last_tx;
            2'd2:    HRDATA[3:0] = status;
            default: HRDATA[3:0] = control;
        endcase
    end

    logic unused_bits;
    assign unused_bits = ^{HADDR[31:4], HADDR[1:0], HTRANS[0], HWDATA[31:8]};
endmodule

// File: tb/tb_ahb_uart.sv
// Testbench for ahb_uart with the serial line looped back (serialRx = serialTx).
// A short bit period of 16 clocks keeps whole frames cheap to simulate.
module tb_ahb_uart;
    localparam int BIT = 16;

    logic        HCLK = 1'b0;
    logic        HRESETn, HSEL, HREADY, HWRITE;
    logic [31:0] HADDR, HWDATA, HRDATA;
    logic [1:0]  HTRANS;
    logic        HREADYOUT, uart_IRQ;
    logic        line;

    int checks = 0;
    int passed = 0;
    logic [31:0] exp_q[$];
    string       name_q[$];

    ahb_uart #(.CLK_HZ(160), .BAUD(10), .FIFO_AW(4)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HREADY(HREADY),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HWDATA(HWDATA),
        .HRDATA(HRDATA), .HREADYOUT(HREADYOUT),
        .serialRx(line), .serialTx(line), .uart_IRQ(uart_IRQ)
    );

    // ---------------- clock ----------------
    always #5 HCLK = ~HCLK;

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Tracks read data phases from the bus itself and compares each one
    // against the oldest expected value.
    logic rd_dphase = 1'b0;
    always @(posedge HCLK) rd_dphase <= HSEL & HREADY & HTRANS[1] & ~HWRITE;

    always @(negedge HCLK) begin
        if (rd_dphase) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_read: got 0x%0h, expected no read", HRDATA);
            end else begin
                check(name_q.pop_front(), HRDATA, exp_q.pop_front());
                check("hreadyout", {31'd0, HREADYOUT}, 32'd1);
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic bus_idle(input int n);
        repeat (n) @(posedge HCLK);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        @(posedge HCLK); #1;
        HSEL = 1'b1; HTRANS = 2'b10; HADDR = addr; HWRITE = 1'b1;
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = data;
    endtask

    task automatic bus_read(input logic [31:0] addr, input logic [31:0] exp, input string name);
        exp_q.push_back(exp);
        name_q.push_back(name);
        @(posedge HCLK); #1;
        HSEL = 1'b1; HTRANS = 2'b10; HADDR = addr; HWRITE = 1'b0;
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00;
    endtask

    task automatic wait_irq(input logic level, input int budget, input string name);
        int n = 0;
        @(negedge HCLK);
        while (uart_IRQ !== level && n < budget) begin
            @(negedge HCLK);
            n++;
        end
        check(name, {31'd0, uart_IRQ}, {31'd0, level});
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] irq_bytes [3];
        irq_bytes[0] = 8'h56; irq_bytes[1] = 8'h34; irq_bytes[2] = 8'd20;

        HRESETn = 1'b0; HSEL = 1'b0; HREADY = 1'b1; HWRITE = 1'b0;
        HADDR = 32'd0; HWDATA = 32'd0; HTRANS = 2'b00;
        repeat (4) @(posedge HCLK);
        #1 HRESETn = 1'b1;

        @(negedge HCLK);
        check("reset_serial_tx", {31'd0, line}, 32'd1);
        check("reset_irq", {31'd0, uart_IRQ}, 32'd0);
        bus_read(32'h8, 32'h2, "reset_status");
        bus_read(32'hC, 32'h0, "reset_control");
        bus_read(32'h0, 32'h0, "reset_rxdata_empty");

        // Writes to RXDATA do nothing.
        bus_write(32'h0, 32'h1a2b3c4d);
        bus_read(32'h8, 32'h2, "status_after_rx_write");
        bus_idle(2);
        @(negedge HCLK);
        check("irq_after_rx_write", {31'd0, uart_IRQ}, 32'd0);

        // Single byte through the loopback.
        bus_write(32'h4, 32'h12345678);
        bus_read(32'h4, 32'h78, "last_tx_byte");
        bus_write(32'hC, 32'hC);
        bus_read(32'h8, 32'h2, "status_tx_shifting");
        wait_irq(1'b1, 40 * BIT, "irq_first_frame");
        bus_read(32'h8, 32'hA, "status_first_frame");
        bus_read(32'h0, 32'h78, "rxdata_first_frame");
        wait_irq(1'b0, 10, "irq_clears_after_pop");

        // Two bytes: one in the shifter, one left in the FIFO.
        bus_write(32'h4, 32'h56);
        bus_write(32'h4, 32'h34);
        bus_read(32'h8, 32'h0, "status_tx_partial");
        bus_read(32'hC, 32'hC, "control_readback");

        // Overfill the TX FIFO; writes past 16 entries are dropped.
        for (int v = 20; v < 40; v++) bus_write(32'h4, v);
        bus_read(32'h8, 32'h1, "status_tx_full");

        // Bytes arrive in order; read after the shifter has reloaded.
        for (int i = 0; i < 3; i++) begin
            wait_irq(1'b1, 40 * BIT, $sformatf("irq_byte%0d", i));
            bus_idle(BIT);
            bus_read(32'h8, 32'h8, $sformatf("status_byte%0d", i));
            bus_read(32'h0, {24'd0, irq_bytes[i]}, $sformatf("rxdata_byte%0d", i));
            wait_irq(1'b0, 10, $sformatf("irq_low_byte%0d", i));
        end
        bus_read(32'h8, 32'h0, "status_rx_drained");

        // Interrupt on TX FIFO empty only.
        bus_write(32'hC, 32'h2);
        bus_idle(2);
        @(negedge HCLK);
        check("irq_tx_not_empty_yet", {31'd0, uart_IRQ}, 32'd0);
        wait_irq(1'b1, 20 * 10 * BIT, "irq_tx_empty");
        bus_read(32'h8, 32'hA, "status_tx_empty");
        bus_read(32'h0, 32'd21, "rxdata_21");

        // Reset while the last byte (34) is still in its start bit.
        @(negedge HCLK);
        check("line_low_before_reset", {31'd0, line}, 32'd0);
        HRESETn = 1'b0;
        @(negedge HCLK);
        check("line_idle_after_reset", {31'd0, line}, 32'd1);
        @(posedge HCLK); #1 HRESETn = 1'b1;
        bus_read(32'h8, 32'h2, "status_after_reset");
        bus_read(32'hC, 32'h0, "control_after_reset");
        bus_read(32'h0, 32'h0, "rxdata_after_reset");
        bus_idle(2);
        @(negedge HCLK);
        check("irq_after_reset", {31'd0, uart_IRQ}, 32'd0);
        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    // Hard time limit.
    initial begin
        #2_000_000;
        $display("FAIL timeout: got no finish, expected finish before limit");
        $fatal(1, "timeout");
    end
endmodule
